// File: rtl/inst_prefetch.sv
// Instruction prefetch buffer between the openmips fetch port and a req/gnt/rvalid memory.
// Slots are allocated at grant (addr tag) and filled in order on rvalid; head pops on core hit.
module inst_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_ce_i,
  input  logic [31:0] core_addr_i,
  output logic [31:0] core_inst_o,
  output logic        stall_req_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  // head..dptr holds returned words, dptr..aptr holds granted-but-pending requests
  logic [PW:0] head_q, head_d, dptr_q, dptr_d, aptr_q, aptr_d;
  logic [31:0] fetch_addr_q, fetch_addr_d, mem_addr_q, mem_addr_d;
  logic        mem_req_q, mem_req_d;
  logic [PW:0] occ, outs, inflight_d;
  logic        grant, rsp, hit, on_path;

  assign occ   = dptr_q - head_q;
  assign outs  = aptr_q - dptr_q;
  assign grant = mem_req_q & mem_gnt_i;
  assign rsp   = mem_rvalid_i & (outs != '0);
  assign hit   = core_ce_i & (occ != '0) & (addr_q[head_q[PW-1:0]] == core_addr_i);

  // An empty buffer is still on the right path if the PC is the next word already in flight
  assign on_path = (occ == '0) &
                   (((outs != '0) & (addr_q[dptr_q[PW-1:0]] == core_addr_i)) |
                    (core_addr_i == fetch_addr_q));

  assign core_inst_o = hit ? data_q[head_q[PW-1:0]] : '0;
  assign stall_req_o = core_ce_i & ~hit & ~rst;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    dptr_d       = dptr_q;
    aptr_d       = aptr_q;
    fetch_addr_d = fetch_addr_q;
    mem_addr_d   = mem_addr_q;
    if (grant) begin
      aptr_d       = aptr_q + 1'b1;
      fetch_addr_d = fetch_addr_q + 32'd4;
    end
    if (rsp) dptr_d = dptr_q + 1'b1;
    if (rsp && state_q == FLUSH) head_d = head_q + 1'b1;
    else if (hit)                head_d = head_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (core_ce_i) begin
          state_d      = FETCH;
          fetch_addr_d = core_addr_i;
        end
      end
      default: begin
        if (!core_ce_i || (!hit && !on_path)) begin
          head_d = dptr_d;
          if (core_ce_i) fetch_addr_d = core_addr_i;
          if (aptr_d != dptr_d) state_d = FLUSH;
          else                  state_d = core_ce_i ? FETCH : IDLE;
        end else if (state_q == FLUSH && aptr_d == dptr_d) begin
          state_d = FETCH;
        end
      end
    endcase
    inflight_d = aptr_d - head_d;
    mem_req_d  = (state_d == FETCH) && (inflight_d < DEPTH_W);
    if (mem_req_d) mem_addr_d = fetch_addr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      head_q       <= '0;
      dptr_q       <= '0;
      aptr_q       <= '0;
      fetch_addr_q <= RESET_PC;
      mem_addr_q   <= '0;
      mem_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      dptr_q       <= dptr_d;
      aptr_q       <= aptr_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) addr_q[aptr_q[PW-1:0]] <= mem_addr_q;
    if (rsp)   data_q[dptr_q[PW-1:0]] <= mem_rdata_i;
  end

endmodule

// File: tb/tb_inst_prefetch.sv
// Scoreboard bench for inst_prefetch: memory model returns ~addr, monitor checks every core hit.
module tb_inst_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_ce_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_inst_o;
  logic        stall_req_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  inst_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .core_ce_i(core_ce_i), .core_addr_i(core_addr_i),
    .core_inst_o(core_inst_o), .stall_req_o(stall_req_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned rdy;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] gnt_log[$];
  logic [31:0] exp_q[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;
  bit          gnt_en = 1'b1;
  bit          rv_en = 1'b1;
  int          vectors = 0;
  int          errors = 0;

  // Memory: in-order responses, data = ~addr, rvalid no earlier than lat cycles after grant
  always @(posedge clk) begin
    if (mem_rvalid_i) void'(pend.pop_front());
    if (mem_req_o && mem_gnt_i) begin
      pend.push_back('{addr: mem_addr_o, rdy: cyc + lat});
      gnt_log.push_back(mem_addr_o);
    end
    cyc++;
    #1;
    mem_gnt_i = gnt_en;
    if (rv_en && pend.size() > 0 && pend[0].rdy <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = ~pend[0].addr;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
    end
  end

  always @(negedge clk) begin
    if (!rst && core_ce_i) begin
      vectors++;
      if (!stall_req_o) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL hit_unexpected: addr %h inst %h, no instruction expected", core_addr_i, core_inst_o);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (core_inst_o !== e) begin
            errors++;
            $display("FAIL hit_data @%h: got %h expected %h", core_addr_i, core_inst_o, e);
          end
        end
      end else if (core_inst_o !== 32'h0) begin
        errors++;
        $display("FAIL stall_inst_zero: got %h expected 00000000", core_inst_o);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Core model: advance PC by 4 after each non-stalled cycle until n instructions delivered
  task automatic run_seq(input logic [31:0] start, input int n, output int stalls);
    logic [31:0] pc;
    int got, cycles;
    bit hit;
    pc = start; got = 0; stalls = 0; cycles = 0;
    core_addr_i = pc;
    core_ce_i   = 1'b1;
    exp_q.push_back(~pc);
    while (got < n && cycles < 200) begin
      @(negedge clk);
      hit = !stall_req_o;
      @(posedge clk); #1;
      cycles++;
      if (hit) begin
        got++;
        if (got < n) begin
          pc = pc + 32'd4;
          core_addr_i = pc;
          exp_q.push_back(~pc);
        end
      end else begin
        stalls++;
      end
    end
    if (got < n) begin
      vectors++;
      errors++;
      $display("FAIL run_seq_timeout @%h: got %0d instructions expected %0d", start, got, n);
      exp_q.delete();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    core_ce_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    while (pend.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("drain_pending", pend.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    bit found;
    rst = 1'b1; core_ce_i = 1'b0; core_addr_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_inst", core_inst_o, 0);
    chk("rst_stall", stall_req_o, 0);

    // Cold start from 0 with single-cycle memory
    @(posedge clk); #1;
    rst = 1'b0;
    run_seq(32'h0, 8, st);
    chk("cold_stalls", st, 3);

    // Grant withheld with request pending at 0x10
    drain();
    @(negedge clk); gnt_en = 1'b0;
    @(posedge clk); #1;
    core_addr_i = 32'h10; core_ce_i = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_req", mem_req_o, 1);
      chk("hold_addr", mem_addr_o, 32'h10);
      chk("hold_stall", stall_req_o, 1);
    end
    gnt_en = 1'b1;
    run_seq(32'h10, 4, st);
    chk("hold_stalls", st, 2);

    // Jump 0x08 -> 0x100 with two-cycle memory, stale responses in flight
    drain();
    @(negedge clk); lat = 2;
    @(posedge clk); #1;
    run_seq(32'h0, 3, st);
    chk("lat2_stalls", st, 4);
    gnt_log.delete();
    run_seq(32'h100, 4, st);
    chk("jump_stalls", st, 6);
    if (gnt_log.size() >= 2) begin
      chk("jump_last_stale_req", gnt_log[0], 32'h18);
      chk("jump_first_req", gnt_log[1], 32'h100);
    end else begin
      chk("jump_req_count", gnt_log.size(), 2);
    end

    // Responses withheld: exactly DEPTH requests issued, then drained in order
    drain();
    @(negedge clk); rv_en = 1'b0; lat = 1;
    @(posedge clk); #1;
    gnt_log.delete();
    core_addr_i = 32'h20; core_ce_i = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("fill_req_count", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      chk("fill_req_addr", gnt_log[i], 32'h20 + 32'(4 * i));
    @(negedge clk);
    chk("fill_req_off", mem_req_o, 0);
    chk("fill_stall", stall_req_o, 1);
    rv_en = 1'b1;
    run_seq(32'h20, 6, st);
    chk("fill_stalls", st, 1);

    // Sequential run across the 32-bit address wrap
    gnt_log.delete();
    run_seq(32'hFFFF_FFF8, 5, st);
    found = 1'b0;
    for (int i = 0; i + 1 < gnt_log.size(); i++) begin
      if (!found && gnt_log[i] == 32'hFFFF_FFFC) begin
        found = 1'b1;
        chk("wrap_next_req", gnt_log[i + 1], 32'h0);
      end
    end
    if (!found) chk("wrap_req_seen", 32'h0, 32'hFFFF_FFFC);

    // Reset with three requests outstanding, late responses afterwards
    drain();
    @(negedge clk); lat = 3;
    @(posedge clk); #1;
    core_addr_i = 32'h200; core_ce_i = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_outstanding", pend.size(), 3);
    rst = 1'b1;
    #1;
    chk("midrst_mem_req", mem_req_o, 0);
    chk("midrst_mem_addr", mem_addr_o, 0);
    chk("midrst_stall", stall_req_o, 0);
    chk("midrst_inst", core_inst_o, 0);
    @(posedge clk); #1;
    rst = 1'b0; core_ce_i = 1'b0;
    @(negedge clk);
    chk("late_rvalid_req", mem_req_o, 0);
    chk("late_rvalid_stall", stall_req_o, 0);
    @(negedge clk);
    chk("late_rvalid_req2", mem_req_o, 0);
    lat = 1;
    @(posedge clk); #1;
    gnt_log.delete();
    run_seq(32'h0, 4, st);
    chk("restart_stalls", st, 3);
    if (gnt_log.size() > 0) chk("restart_first_req", gnt_log[0], 32'h0);
    else chk("restart_req_count", gnt_log.size(), 1);

    drain();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
